// File: rtl/opcode_fetch_unit.sv
// Two-byte instruction fetcher: reads a byte-wide synchronous program memory and queues
// {opcode1, opcode2, address} entries for the CPU. Define FETCH_PERF_EN to add perf counters.
module opcode_fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 2,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
`ifdef FETCH_PERF_EN
  output logic [15:0]       fetch_count,
  output logic [15:0]       stall_count,
`endif
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        opcode1,
  output logic [7:0]        opcode2,
  output logic [ADDR_W-1:0] rom_address,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {F0, F1, F2, HOLD} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] fetch_pc_reg;
  logic [7:0]        byte0_reg;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [7:0]        last_op1_reg, last_op2_reg;
  logic [ADDR_W-1:0] last_pc_reg;

  logic [7:0]        q_op1 [DEPTH];
  logic [7:0]        q_op2 [DEPTH];
  logic [ADDR_W-1:0] q_pc  [DEPTH];

  logic             pop, push, space;
  logic [CNT_W-1:0] count_next;

  assign instr_valid = (count_reg != '0);
  assign pop         = instr_valid & instr_ready;
  // A redirect kills the pair completing in F2, so it never reaches the queue.
  assign push        = (state_reg == F2) & ~redirect_en;
  assign count_next  = count_reg - CNT_W'(pop) + CNT_W'(push);
  assign space       = (count_next < CNT_W'(DEPTH));

  assign mem_rd_en = (state_reg == F0) || (state_reg == F1);
  assign mem_addr  = (state_reg == F1) ? fetch_pc_reg + ADDR_W'(1) : fetch_pc_reg;

  // With the queue empty the outputs keep showing the last instruction handed over.
  assign opcode1     = instr_valid ? q_op1[rd_ptr_reg] : last_op1_reg;
  assign opcode2     = instr_valid ? q_op2[rd_ptr_reg] : last_op2_reg;
  assign rom_address = instr_valid ? q_pc[rd_ptr_reg]  : last_pc_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      q_op1[wr_ptr_reg] <= byte0_reg;
      q_op2[wr_ptr_reg] <= mem_rdata;
      q_pc[wr_ptr_reg]  <= fetch_pc_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= F0;
      fetch_pc_reg <= PC_INIT;
      byte0_reg    <= 8'h00;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      last_op1_reg <= 8'h00;
      last_op2_reg <= 8'h00;
      last_pc_reg  <= PC_INIT;
    end else begin
      if (pop) begin
        last_op1_reg <= q_op1[rd_ptr_reg];
        last_op2_reg <= q_op2[rd_ptr_reg];
        last_pc_reg  <= q_pc[rd_ptr_reg];
      end
      if (redirect_en) begin
        state_reg    <= F0;
        fetch_pc_reg <= redirect_addr;
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        count_reg    <= '0;
      end else begin
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        count_reg <= count_next;
        case (state_reg)
          F0: state_reg <= F1;
          F1: begin
            byte0_reg <= mem_rdata;
            state_reg <= F2;
          end
          F2: begin
            fetch_pc_reg <= fetch_pc_reg + ADDR_W'(2);
            state_reg    <= space ? F0 : HOLD;
          end
          HOLD: if (space) state_reg <= F0;
          default: state_reg <= F0;
        endcase
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= 16'h0000;
      stall_count <= 16'h0000;
    end else begin
      if (push && fetch_count != 16'hFFFF)
        fetch_count <= fetch_count + 16'd1;
      if (state_reg == HOLD && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end
`else
  // Counters and their ports are absent in this build.
`endif

endmodule

// File: tb/tb_opcode_fetch_unit.sv
// Self-checking bench for opcode_fetch_unit: directed scenarios plus a randomized run
// against an instruction-stream model (pairs at pc, pc+2, ... restarting at jump targets).
module tb_opcode_fetch_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mem_rd_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] opcode1, opcode2, rom_address;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic       redirect_en = 1'b0;
  logic [7:0] redirect_addr = 8'h00;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count, stall_count;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [256];

  opcode_fetch_unit #(.ADDR_W(8), .DEPTH(2), .RESET_PC(0)) dut (
    .clk(clk),
    .reset(reset),
`ifdef FETCH_PERF_EN
    .fetch_count(fetch_count),
    .stall_count(stall_count),
`endif
    .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .opcode1(opcode1),
    .opcode2(opcode2),
    .rom_address(rom_address),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect_en(redirect_en),
    .redirect_addr(redirect_addr)
  );

  always #5 clk = ~clk;

  // Synchronous program memory: data appears the cycle after the request.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instr_ready = 1'b0;
    redirect_en = 1'b0;
    redirect_addr = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Holds ready high until one instruction is accepted or the budget runs out.
  task automatic wait_pop(input int budget, output logic [7:0] b0, output logic [7:0] b1,
                          output logic [7:0] a, output bit ok);
    ok = 1'b0;
    b0 = 8'h00; b1 = 8'h00; a = 8'h00;
    instr_ready = 1'b1;
    for (int i = 0; i < budget && !ok; i++) begin
      if (instr_valid) begin
        b0 = opcode1; b1 = opcode2; a = rom_address;
        ok = 1'b1;
      end
      tick();
    end
    if (ok) $display("pop  op1=%02h op2=%02h addr=%02h", b0, b1, a);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0 || opcode1 !== 8'h00 || opcode2 !== 8'h00 || rom_address !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: valid=%b op1=%02h op2=%02h addr=%02h required 0/00/00/00",
               instr_valid, opcode1, opcode2, rom_address);
    end
    mem[0] = 8'h10; mem[1] = 8'hFF;
    reset = 1'b0;
    repeat (4) tick();  // one pair queued, fetch now in F1
    checks++;
    if (instr_valid !== 1'b1 || opcode1 !== 8'h10 || mem_addr !== 8'h03 || mem_rd_en !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_f1: valid=%b op1=%02h rd_en=%b addr=%02h required 1/10/1/03",
               instr_valid, opcode1, mem_rd_en, mem_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || opcode1 !== 8'h00 || opcode2 !== 8'h00 || rom_address !== 8'h00 ||
        mem_rd_en !== 1'b1 || mem_addr !== 8'h00) begin
      failures++;
      $display("FAIL async_reset: valid=%b op1=%02h op2=%02h addr=%02h rd_en=%b mem_addr=%02h required 0/00/00/00/1/00",
               instr_valid, opcode1, opcode2, rom_address, mem_rd_en, mem_addr);
    end
  endtask

  task automatic test_load_store();
    logic [7:0] b0, b1, a;
    bit ok;
    mem[0] = 8'h10; mem[1] = 8'hFF; mem[2] = 8'h30;
    mem[3] = 8'h83; mem[4] = 8'h20; mem[5] = 8'h83;
    do_reset();
    instr_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL early_valid: valid=%b after 2 edges required 0", instr_valid);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || opcode1 !== 8'h10 || opcode2 !== 8'hFF || rom_address !== 8'h00) begin
      failures++;
      $display("FAIL first_valid: valid=%b op1=%02h op2=%02h addr=%02h required 1/10/FF/00",
               instr_valid, opcode1, opcode2, rom_address);
    end
    tick();
    wait_pop(10, b0, b1, a, ok);
    checks++;
    if (!ok || b0 !== 8'h30 || b1 !== 8'h83 || a !== 8'h02) begin
      failures++;
      $display("FAIL ls_pair2: ok=%b got %02h,%02h@%02h required 30,83@02", ok, b0, b1, a);
    end
    wait_pop(10, b0, b1, a, ok);
    checks++;
    if (!ok || b0 !== 8'h20 || b1 !== 8'h83 || a !== 8'h04) begin
      failures++;
      $display("FAIL ls_pair3: ok=%b got %02h,%02h@%02h required 20,83@04", ok, b0, b1, a);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] b0, b1, a;
    bit ok;
    bit rd_seen;
    do_reset();
    repeat (12) tick();
    rd_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_seen |= mem_rd_en;
      tick();
    end
    checks++;
    if (rd_seen !== 1'b0 || instr_valid !== 1'b1 || opcode1 !== 8'h10 || rom_address !== 8'h00) begin
      failures++;
      $display("FAIL bp_hold: rd_en_seen=%b valid=%b op1=%02h addr=%02h required 0/1/10/00",
               rd_seen, instr_valid, opcode1, rom_address);
    end
    for (int k = 0; k < 3; k++) begin
      wait_pop(12, b0, b1, a, ok);
      checks++;
      if (!ok || a !== 8'(2 * k) || b0 !== mem[2 * k] || b1 !== mem[2 * k + 1]) begin
        failures++;
        $display("FAIL bp_drain%0d: ok=%b got %02h,%02h@%02h required %02h,%02h@%02h",
                 k, ok, b0, b1, a, mem[2 * k], mem[2 * k + 1], 8'(2 * k));
      end
    end
  endtask

  task automatic test_redirect();
    logic [7:0] b0, b1, a;
    bit ok;
    mem[8'h40] = 8'hA5; mem[8'h41] = 8'h5A;
    do_reset();
    repeat (4) tick();
    redirect_en = 1'b1;
    redirect_addr = 8'h40;
    tick();
    redirect_en = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL redirect_flush: valid=%b required 0", instr_valid);
    end
    wait_pop(10, b0, b1, a, ok);
    checks++;
    if (!ok || b0 !== 8'hA5 || b1 !== 8'h5A || a !== 8'h40) begin
      failures++;
      $display("FAIL redirect_target: ok=%b got %02h,%02h@%02h required A5,5A@40", ok, b0, b1, a);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] b0, b1, a;
    bit ok;
    mem[8'hFF] = 8'h11; mem[0] = 8'h22; mem[1] = 8'h33; mem[2] = 8'h44;
    do_reset();
    instr_ready = 1'b1;
    tick();
    redirect_en = 1'b1;
    redirect_addr = 8'hFF;
    tick();
    redirect_en = 1'b0;
    wait_pop(10, b0, b1, a, ok);
    checks++;
    if (!ok || b0 !== 8'h11 || b1 !== 8'h22 || a !== 8'hFF) begin
      failures++;
      $display("FAIL wrap_pair: ok=%b got %02h,%02h@%02h required 11,22@FF", ok, b0, b1, a);
    end
    wait_pop(10, b0, b1, a, ok);
    checks++;
    if (!ok || b0 !== 8'h33 || b1 !== 8'h44 || a !== 8'h01) begin
      failures++;
      $display("FAIL wrap_next: ok=%b got %02h,%02h@%02h required 33,44@01", ok, b0, b1, a);
    end
  endtask

  task automatic test_random();
    logic [7:0] pc, pc1, e0, e1;
    logic [7:0] last0, last1, lasta;
    int idle;
    int pops;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    do_reset();
    pc = 8'h00;
    last0 = 8'h00; last1 = 8'h00; lasta = 8'h00;
    idle = 0;
    pops = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!instr_valid) begin
        idle++;
        checks++;
        if (opcode1 !== last0 || opcode2 !== last1 || rom_address !== lasta) begin
          failures++;
          $display("FAIL rnd_hold cyc=%0d: got %02h,%02h@%02h required %02h,%02h@%02h",
                   cyc, opcode1, opcode2, rom_address, last0, last1, lasta);
        end
        if (idle > 8) begin
          failures++;
          $display("FAIL rnd_stuck cyc=%0d: valid low %0d cycles required <=8", cyc, idle);
          break;
        end
      end else begin
        idle = 0;
      end
      instr_ready = ($urandom_range(0, 99) < 60);
      redirect_en = ($urandom_range(0, 49) == 0);
      redirect_addr = 8'($urandom);
      if (instr_valid && instr_ready) begin
        pc1 = pc + 8'd1;
        e0 = mem[pc];
        e1 = mem[pc1];
        checks++;
        pops++;
        if (opcode1 !== e0 || opcode2 !== e1 || rom_address !== pc) begin
          failures++;
          $display("FAIL rnd_pop cyc=%0d: got %02h,%02h@%02h required %02h,%02h@%02h",
                   cyc, opcode1, opcode2, rom_address, e0, e1, pc);
        end
        last0 = e0; last1 = e1; lasta = pc;
        pc = pc + 8'd2;
      end
      if (redirect_en) begin
        pc = redirect_addr;
        idle = 0;
      end
      tick();
    end
    redirect_en = 1'b0;
    instr_ready = 1'b0;
    $display("random run: %0d instructions accepted", pops);
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    do_reset();
    repeat (9) tick();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if (fetch_count !== 16'd3 || stall_count !== 16'd4) begin
      failures++;
      $display("FAIL perf_counts: fetch=%0d stall=%0d required 3/4", fetch_count, stall_count);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_load_store();
    test_backpressure();
    test_redirect();
    test_wrap();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
